// File: rtl/pong_pkg.sv
// Shared playfield geometry and collision-stage state encoding.
package pong_pkg;

    localparam int SCREEN_W   = 240;
    localparam int SCREEN_H   = 320;
    localparam int BALL_SZ    = 8;
    localparam int PADDLE_W   = 4;
    localparam int PADDLE_H   = 48;
    localparam int LEFT_PX    = 16;
    localparam int RIGHT_PX   = 220;
    localparam int WIN_PTS    = 7;
    localparam int SERVE_CYC  = 50;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_e;

endpackage

// File: rtl/score_counter.sv
// 4-bit saturating score counter with clear, increment and max flag.
module score_counter
    import pong_pkg::*;
#(
    parameter int MAX = WIN_PTS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] count,
    output logic       atMax
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    assign atMax = (count_q == 4'(MAX));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 4'd0;
        end else if (inc && !atMax) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ball_collision_detector.sv
// Paddle/wall bounce detection, goal scoring and serve timing
// for the stage feeding the ball mover.
module ball_collision_detector
    import pong_pkg::*;
#(
    parameter int SCREEN_WIDTH   = SCREEN_W,
    parameter int SCREEN_HEIGHT  = SCREEN_H,
    parameter int BALL_SIZE      = BALL_SZ,
    parameter int PADDLE_WIDTH   = PADDLE_W,
    parameter int PADDLE_HEIGHT  = PADDLE_H,
    parameter int LEFT_PADDLE_X  = LEFT_PX,
    parameter int RIGHT_PADDLE_X = RIGHT_PX,
    parameter int WIN_SCORE      = WIN_PTS,
    parameter int SERVE_DELAY    = SERVE_CYC
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ballXValue,
    input  logic [8:0] ballYValue,
    input  logic       direction,
    input  logic [8:0] leftPaddleY,
    input  logic [8:0] rightPaddleY,
    input  logic       newGame,
    output logic       changeXDirection,
    output logic       changeYDirection,
    output logic       pointScored,
    output logic       serveRequest,
    output logic [3:0] scoreLeft,
    output logic [3:0] scoreRight,
    output logic       gameOver
);

    localparam int HW = $clog2(SERVE_DELAY + 1);

    state_e          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            ylock_q, ylock_d;
    logic            cx_q, cx_d;
    logic            cy_q, cy_d;
    logic            pt_q, pt_d;
    logic            srv_q, srv_d;
    logic            over_q, over_d;

    logic            inc_left, inc_right, clr_scores;
    logic            left_max, right_max;

    logic [9:0] bx, by, lpy, rpy;
    logic [9:0] bx_end, by_end, lpy_end, rpy_end;
    logic       left_hit, right_hit, wall_hit;
    logic       goal_left, goal_right;
    logic       left_y_ovl, right_y_ovl;

    assign bx      = {2'b00, ballXValue};
    assign by      = {1'b0, ballYValue};
    assign lpy     = {1'b0, leftPaddleY};
    assign rpy     = {1'b0, rightPaddleY};
    assign bx_end  = bx + 10'(BALL_SIZE);
    assign by_end  = by + 10'(BALL_SIZE);
    assign lpy_end = lpy + 10'(PADDLE_HEIGHT);
    assign rpy_end = rpy + 10'(PADDLE_HEIGHT);

    assign left_y_ovl  = (by_end > lpy) && (by < lpy_end);
    assign right_y_ovl = (by_end > rpy) && (by < rpy_end);

    assign left_hit = !direction
        && (bx <= 10'(LEFT_PADDLE_X + PADDLE_WIDTH))
        && (bx_end > 10'(LEFT_PADDLE_X))
        && left_y_ovl;

    assign right_hit = direction
        && (bx_end >= 10'(RIGHT_PADDLE_X))
        && (bx < 10'(RIGHT_PADDLE_X + PADDLE_WIDTH))
        && right_y_ovl;

    assign wall_hit   = (by == 10'd0) || (by_end >= 10'(SCREEN_HEIGHT));
    assign goal_left  = !direction && (bx == 10'd0);
    assign goal_right = direction && (bx_end >= 10'(SCREEN_WIDTH));

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        ylock_d    = ylock_q;
        cx_d       = 1'b0;
        cy_d       = 1'b0;
        pt_d       = 1'b0;
        srv_d      = 1'b0;
        inc_left   = 1'b0;
        inc_right  = 1'b0;
        clr_scores = 1'b0;
        if (newGame) begin
            clr_scores = 1'b1;
            state_d    = ST_HOLD;
            hold_d     = '0;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (goal_left) begin
                        inc_right = 1'b1;
                        pt_d      = 1'b1;
                        hold_d    = '0;
                        state_d   = (scoreRight == 4'(WIN_SCORE - 1))
                                    ? ST_OVER : ST_HOLD;
                    end else if (goal_right) begin
                        inc_left = 1'b1;
                        pt_d     = 1'b1;
                        hold_d   = '0;
                        state_d  = (scoreLeft == 4'(WIN_SCORE - 1))
                                   ? ST_OVER : ST_HOLD;
                    end else begin
                        cx_d = left_hit || right_hit;
                        // yLock keeps a ball resting on a wall from re-bouncing
                        if (wall_hit && !ylock_q) begin
                            cy_d    = 1'b1;
                            ylock_d = 1'b1;
                        end else if (!wall_hit) begin
                            ylock_d = 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HW'(SERVE_DELAY - 1)) begin
                        srv_d   = 1'b1;
                        ylock_d = 1'b0;
                        hold_d  = '0;
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER: begin
                end
                default: begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            endcase
        end
        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            ylock_q <= 1'b0;
            cx_q    <= 1'b0;
            cy_q    <= 1'b0;
            pt_q    <= 1'b0;
            srv_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ylock_q <= ylock_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            pt_q    <= pt_d;
            srv_q   <= srv_d;
            over_q  <= over_d;
        end
    end

    score_counter #(.MAX(WIN_SCORE)) u_left (
        .clock (clock),
        .reset (reset),
        .clear (clr_scores),
        .inc   (inc_left),
        .count (scoreLeft),
        .atMax (left_max)
    );

    score_counter #(.MAX(WIN_SCORE)) u_right (
        .clock (clock),
        .reset (reset),
        .clear (clr_scores),
        .inc   (inc_right),
        .count (scoreRight),
        .atMax (right_max)
    );

    assign changeXDirection = cx_q;
    assign changeYDirection = cy_q;
    assign pointScored      = pt_q;
    assign serveRequest     = srv_q;
    assign gameOver         = over_q;

endmodule

// File: tb/tb_ball_collision_detector.sv
// Scoreboard bench: expected outputs queued per driven cycle, popped after the edge.
module tb_ball_collision_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] ballXValue;
    logic [8:0] ballYValue;
    logic       direction;
    logic [8:0] leftPaddleY;
    logic [8:0] rightPaddleY;
    logic       newGame;
    logic       changeXDirection;
    logic       changeYDirection;
    logic       pointScored;
    logic       serveRequest;
    logic [3:0] scoreLeft;
    logic [3:0] scoreRight;
    logic       gameOver;

    typedef struct packed {
        logic       cx;
        logic       cy;
        logic       pt;
        logic       srv;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] exp_sl = 4'd0;
    logic [3:0] exp_sr = 4'd0;
    logic       exp_go = 1'b0;

    always #5 clock = ~clock;

    ball_collision_detector dut (
        .clock            (clock),
        .reset            (reset),
        .ballXValue       (ballXValue),
        .ballYValue       (ballYValue),
        .direction        (direction),
        .leftPaddleY      (leftPaddleY),
        .rightPaddleY     (rightPaddleY),
        .newGame          (newGame),
        .changeXDirection (changeXDirection),
        .changeYDirection (changeYDirection),
        .pointScored      (pointScored),
        .serveRequest     (serveRequest),
        .scoreLeft        (scoreLeft),
        .scoreRight       (scoreRight),
        .gameOver         (gameOver)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int bx, input int by, input logic dir,
                          input int lpy, input int rpy);
        ballXValue   = 8'(bx);
        ballYValue   = 9'(by);
        direction    = dir;
        leftPaddleY  = 9'(lpy);
        rightPaddleY = 9'(rpy);
    endtask

    task automatic neutral();
        set_in(100, 150, 1'b1, 0, 0);
    endtask

    task automatic tick(input string tag, input logic cx, input logic cy,
                        input logic pt, input logic srv);
        exp_t e;
        e = '{cx: cx, cy: cy, pt: pt, srv: srv,
              sl: exp_sl, sr: exp_sr, go: exp_go};
        q.push_back(e);
        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, ".cx"}, 32'(changeXDirection), 32'(e.cx));
            chk({tag, ".cy"}, 32'(changeYDirection), 32'(e.cy));
            chk({tag, ".pt"}, 32'(pointScored), 32'(e.pt));
            chk({tag, ".srv"}, 32'(serveRequest), 32'(e.srv));
            chk({tag, ".sl"}, 32'(scoreLeft), 32'(e.sl));
            chk({tag, ".sr"}, 32'(scoreRight), 32'(e.sr));
            chk({tag, ".go"}, 32'(gameOver), 32'(e.go));
        end
    endtask

    task automatic serve(input string tag);
        neutral();
        for (int i = 0; i < 49; i++) tick(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        tick({tag, ".srv_at_50"}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic right_goal(input string tag);
        set_in(0, 200, 1'b0, 20, 150);
        if (exp_sr < 4'd7) exp_sr = exp_sr + 4'd1;
        if (exp_sr == 4'd7) exp_go = 1'b1;
        tick(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cx"}, 32'(changeXDirection), 32'd0);
        chk({tag, ".cy"}, 32'(changeYDirection), 32'd0);
        chk({tag, ".pt"}, 32'(pointScored), 32'd0);
        chk({tag, ".srv"}, 32'(serveRequest), 32'd0);
        chk({tag, ".sl"}, 32'(scoreLeft), 32'd0);
        chk({tag, ".sr"}, 32'(scoreRight), 32'd0);
        chk({tag, ".go"}, 32'(gameOver), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        newGame = 1'b0;
        neutral();
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        serve("boot");
        tick("play_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        set_in(211, 100, 1'b1, 0, 80);
        tick("rhit_edge_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(212, 100, 1'b1, 0, 80);
        tick("rhit", 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(212, 100, 1'b0, 0, 80);
        for (int i = 0; i < 5; i++) tick("rhit_norepeat", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(20, 100, 1'b0, 80, 0);
        tick("lhit_edge", 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(21, 100, 1'b0, 80, 0);
        tick("lhit_past", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(9, 100, 1'b0, 80, 0);
        tick("lhit_inner", 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(8, 100, 1'b0, 80, 0);
        tick("lhit_inner_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(10, 72, 1'b0, 80, 0);
        tick("lhit_above_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(10, 127, 1'b0, 80, 0);
        tick("lhit_below_edge", 1'b1, 1'b0, 1'b0, 1'b0);

        set_in(100, 0, 1'b1, 0, 0);
        tick("wall_top", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("wall_top_lock", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(100, 5, 1'b1, 0, 0);
        tick("wall_off", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(100, 0, 1'b1, 0, 0);
        tick("wall_top2", 1'b0, 1'b1, 1'b0, 1'b0);
        set_in(100, 100, 1'b1, 0, 0);
        tick("wall_clear", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(100, 311, 1'b1, 0, 0);
        tick("wall_bot_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(100, 312, 1'b1, 0, 0);
        tick("wall_bot", 1'b0, 1'b1, 1'b0, 1'b0);

        set_in(100, 100, 1'b1, 0, 0);
        tick("pre_corner", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(212, 312, 1'b1, 0, 290);
        tick("corner", 1'b1, 1'b1, 1'b0, 1'b0);
        set_in(212, 100, 1'b0, 0, 290);
        tick("post_corner", 1'b0, 1'b0, 1'b0, 1'b0);

        right_goal("goal_r1");
        serve("hold_r1");

        set_in(231, 100, 1'b1, 0, 200);
        tick("goal_l_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(232, 100, 1'b1, 0, 200);
        exp_sl = 4'd1;
        tick("goal_l", 1'b0, 1'b0, 1'b1, 1'b0);
        serve("hold_l1");

        for (int g = 2; g <= 7; g++) begin
            right_goal($sformatf("goal_r%0d", g));
            if (g < 7) serve($sformatf("hold_r%0d", g));
        end
        set_in(0, 200, 1'b0, 20, 150);
        for (int i = 0; i < 3; i++) tick("over_goal", 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(212, 312, 1'b1, 0, 290);
        for (int i = 0; i < 55; i++) tick("over_frozen", 1'b0, 1'b0, 1'b0, 1'b0);

        newGame = 1'b1;
        exp_sl = 4'd0;
        exp_sr = 4'd0;
        exp_go = 1'b0;
        tick("newgame", 1'b0, 1'b0, 1'b0, 1'b0);
        newGame = 1'b0;
        serve("ng_hold");

        set_in(0, 200, 1'b0, 20, 150);
        newGame = 1'b1;
        tick("ng_vs_goal", 1'b0, 1'b0, 1'b0, 1'b0);
        newGame = 1'b0;
        serve("ng2_hold");

        right_goal("goal_pre_rst");
        neutral();
        for (int i = 0; i < 5; i++) tick("hold_pre_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        #1;
        reset = 1'b0;
        exp_sr = 4'd0;
        serve("rst_hold");
        tick("end_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
